// File: rtl/bus_reg_pkg.sv
// Shared constants and types for the bus register slave: register offsets,
// CTRL/STATUS bit positions and the timer FSM state encoding.
package bus_reg_pkg;

    localparam logic [2:0] OFS_ID      = 3'd0;
    localparam logic [2:0] OFS_SCRATCH = 3'd1;
    localparam logic [2:0] OFS_CTRL    = 3'd2;
    localparam logic [2:0] OFS_LOAD    = 3'd3;
    localparam logic [2:0] OFS_COUNT   = 3'd4;
    localparam logic [2:0] OFS_STATUS  = 3'd5;
    localparam logic [2:0] OFS_WRCNT   = 3'd6;
    localparam logic [2:0] OFS_RSVD    = 3'd7;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_IRQ  = 2;
    localparam int ST_EXP    = 0;
    localparam int ST_BUSY   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/bus_timer_core.sv
// Reloadable down-counter timer: start loads COUNT, expiry pulses when COUNT
// reaches zero in RUN, then either reloads or drops back to IDLE.
module bus_timer_core
    import bus_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_load,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_auto_reload,
    output logic [15:0] o_count,
    output logic        o_expire,
    output logic        o_busy
);

    timer_state_e r_state, w_state_nxt;
    logic [15:0]  r_count, w_count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // A stop request outranks an expiry on the same edge; COUNT freezes.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_count_nxt = i_load;
                end
            end
            RUN: begin
                if (i_stop) begin
                    w_state_nxt = IDLE;
                end else if (r_count != 16'h0000) begin
                    w_count_nxt = r_count - 16'h0001;
                end else if (i_auto_reload) begin
                    w_count_nxt = i_load;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_count  = r_count;
        o_busy   = (r_state == RUN);
        o_expire = (r_state == RUN) && !i_stop && (r_count == 16'h0000);
    end

endmodule

// File: rtl/bus_reg_slave.sv
// CPU register bus responder: 8-word window with ID, scratch, control and a
// timer; read data is registered and forced to 0 on non-read edges for OR-ing.
module bus_reg_slave
    import bus_reg_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] ID_VALUE  = 16'hB5A1,
    parameter logic [15:0] LOAD_RST  = 16'h00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_cs,
    input  logic        bus_op,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wr_data,
    output logic [15:0] bus_rd_data,
    output logic        irq
);

    logic [15:0] r_scratch, r_load, r_wrcnt, r_rd_data;
    logic [2:0]  r_ctrl, w_ctrl_nxt;
    logic        r_expired, w_exp_nxt, r_irq;
    logic        w_hit, w_wr, w_rd, w_ctrl_wr, w_status_wr;
    logic [2:0]  w_ofs;
    logic [15:0] w_count, w_rd_mux;
    logic        w_expire, w_busy, w_start, w_stop;

    assign w_hit       = bus_cs && (bus_addr[15:3] == BASE_ADDR[15:3]);
    assign w_ofs       = bus_addr[2:0];
    assign w_wr        = w_hit && bus_op;
    assign w_rd        = w_hit && !bus_op;
    assign w_ctrl_wr   = w_wr && (w_ofs == OFS_CTRL);
    assign w_status_wr = w_wr && (w_ofs == OFS_STATUS);
    // Only an en 0->1 transition starts the timer; en=1 while running is a no-op.
    assign w_start     = w_ctrl_wr && bus_wr_data[CTRL_EN] && !r_ctrl[CTRL_EN];
    assign w_stop      = w_ctrl_wr && !bus_wr_data[CTRL_EN];

    bus_timer_core u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_load        (r_load),
        .i_start       (w_start),
        .i_stop        (w_stop),
        .i_auto_reload (r_ctrl[CTRL_AR]),
        .o_count       (w_count),
        .o_expire      (w_expire),
        .o_busy        (w_busy)
    );

    // One-shot expiry clears en so CTRL tracks the FSM dropping to IDLE.
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_ctrl_wr)
            w_ctrl_nxt = bus_wr_data[2:0];
        if (w_expire && !r_ctrl[CTRL_AR])
            w_ctrl_nxt[CTRL_EN] = 1'b0;
        w_exp_nxt = r_expired;
        if (w_status_wr && bus_wr_data[ST_EXP])
            w_exp_nxt = 1'b0;
        if (w_expire)
            w_exp_nxt = 1'b1;
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        case (w_ofs)
            OFS_ID:      w_rd_mux = ID_VALUE;
            OFS_SCRATCH: w_rd_mux = r_scratch;
            OFS_CTRL:    w_rd_mux = {13'h0000, r_ctrl};
            OFS_LOAD:    w_rd_mux = r_load;
            OFS_COUNT:   w_rd_mux = w_count;
            OFS_STATUS:  w_rd_mux = {14'h0000, w_busy, r_expired};
            OFS_WRCNT:   w_rd_mux = r_wrcnt;
            OFS_RSVD:    w_rd_mux = 16'h0000;
            default:     w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scratch <= 16'h0000;
            r_load    <= LOAD_RST;
            r_wrcnt   <= 16'h0000;
            r_rd_data <= 16'h0000;
            r_ctrl    <= 3'b000;
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_ctrl    <= w_ctrl_nxt;
            r_expired <= w_exp_nxt;
            r_irq     <= w_ctrl_nxt[CTRL_IRQ] && w_exp_nxt;
            r_rd_data <= w_rd ? w_rd_mux : 16'h0000;
            if (w_wr) begin
                r_wrcnt <= r_wrcnt + 16'h0001;
                if (w_ofs == OFS_SCRATCH) r_scratch <= bus_wr_data;
                if (w_ofs == OFS_LOAD)    r_load    <= bus_wr_data;
            end
        end
    end

    assign bus_rd_data = r_rd_data;
    assign irq         = r_irq;

endmodule

// File: tb/tb_bus_reg_slave.sv
// Directed self-checking bench for bus_reg_slave; inputs change 1 time unit
// after each rising edge and outputs are sampled at that same point.
module tb_bus_reg_slave;

    localparam logic [15:0] BASE = 16'h0000;

    logic        clk, rst, bus_cs, bus_op, irq;
    logic [15:0] bus_addr, bus_wr_data, bus_rd_data;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int wr_exp   = 0;

    logic [15:0] exp_rst [8];

    bus_reg_slave #(.BASE_ADDR(BASE), .ID_VALUE(16'hB5A1), .LOAD_RST(16'h00FF)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_cs      (bus_cs),
        .bus_op      (bus_op),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic cs, input logic op, input logic [15:0] addr, input logic [15:0] data);
        bus_cs = cs; bus_op = op; bus_addr = addr; bus_wr_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] ofs, input logic [15:0] data);
        cyc(1'b1, 1'b1, BASE + {13'h0, ofs}, data);
        wr_exp++;
    endtask

    task automatic rd(input logic [2:0] ofs);
        cyc(1'b1, 1'b0, BASE + {13'h0, ofs}, 16'h0000);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_cs = 1'b0; bus_op = 1'b0; bus_addr = 16'h0; bus_wr_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        tot_cnt++;
        if (bus_rd_data !== 16'h0000) $display("FAIL rst_rd_data got %h want 0000", bus_rd_data);
        else pass_cnt++;
        tot_cnt++;
        if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            tot_cnt++;
            if (bus_rd_data !== exp_rst[i]) $display("FAIL rst_read ofs %0d got %h want %h", i, bus_rd_data, exp_rst[i]);
            else pass_cnt++;
            idle();
            tot_cnt++;
            if (bus_rd_data !== 16'h0000) $display("FAIL rd_zero_after ofs %0d got %h want 0000", i, bus_rd_data);
            else pass_cnt++;
        end
        tot_cnt++;
        if (irq !== 1'b0) $display("FAIL rst_irq_after got %b want 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_scratch();
        wr(3'd1, 16'hA5A5);
        rd(3'd1);
        tot_cnt++;
        if (bus_rd_data !== 16'hA5A5) $display("FAIL scratch got %h want a5a5", bus_rd_data);
        else pass_cnt++;
        wr(3'd0, 16'h1234);
        rd(3'd0);
        tot_cnt++;
        if (bus_rd_data !== 16'hB5A1) $display("FAIL id_ro got %h want b5a1", bus_rd_data);
        else pass_cnt++;
        rd(3'd6);
        tot_cnt++;
        if (bus_rd_data !== 16'h0002) $display("FAIL wrcnt2 got %h want 0002", bus_rd_data);
        else pass_cnt++;
    endtask

    task automatic test_timer_oneshot();
        logic [15:0] exp_cnt [4];
        exp_cnt = '{16'd3, 16'd2, 16'd1, 16'd0};
        wr(3'd3, 16'h0003);
        wr(3'd2, 16'h0005);
        for (int i = 0; i < 4; i++) begin
            rd(3'd4);
            tot_cnt++;
            if (bus_rd_data !== exp_cnt[i]) $display("FAIL count_seq %0d got %h want %h", i, bus_rd_data, exp_cnt[i]);
            else pass_cnt++;
            if (i == 2) begin
                tot_cnt++;
                if (irq !== 1'b0) $display("FAIL irq_early got %b want 0", irq);
                else pass_cnt++;
            end
        end
        tot_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_expiry got %b want 1", irq);
        else pass_cnt++;
        rd(3'd5);
        tot_cnt++;
        if (bus_rd_data !== 16'h0001) $display("FAIL status_oneshot got %h want 0001", bus_rd_data);
        else pass_cnt++;
        rd(3'd2);
        tot_cnt++;
        if (bus_rd_data !== 16'h0004) $display("FAIL ctrl_en_clr got %h want 0004", bus_rd_data);
        else pass_cnt++;
    endtask

    task automatic test_autoreload();
        wr(3'd3, 16'h0000);
        wr(3'd2, 16'h0007);
        wr(3'd5, 16'h0001);
        rd(3'd5);
        tot_cnt++;
        if (bus_rd_data !== 16'h0003) $display("FAIL w1c_set_wins got %h want 0003", bus_rd_data);
        else pass_cnt++;
        tot_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_autoreload got %b want 1", irq);
        else pass_cnt++;
        wr(3'd2, 16'h0000);
        wr(3'd5, 16'h0001);
        rd(3'd5);
        tot_cnt++;
        if (bus_rd_data !== 16'h0000) $display("FAIL status_cleared got %h want 0000", bus_rd_data);
        else pass_cnt++;
        tot_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_cleared got %b want 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_run_boundary();
        wr(3'd3, 16'h0005);
        wr(3'd2, 16'h0001);
        idle();
        wr(3'd3, 16'h0009);
        wr(3'd2, 16'h0001);
        rd(3'd4);
        tot_cnt++;
        if (bus_rd_data !== 16'h0002) $display("FAIL no_restart got %h want 0002", bus_rd_data);
        else pass_cnt++;
        wr(3'd2, 16'h0000);
        rd(3'd4);
        tot_cnt++;
        if (bus_rd_data !== 16'h0001) $display("FAIL freeze_a got %h want 0001", bus_rd_data);
        else pass_cnt++;
        rd(3'd4);
        tot_cnt++;
        if (bus_rd_data !== 16'h0001) $display("FAIL freeze_b got %h want 0001", bus_rd_data);
        else pass_cnt++;
        rd(3'd5);
        tot_cnt++;
        if (bus_rd_data !== 16'h0000) $display("FAIL stop_status got %h want 0000", bus_rd_data);
        else pass_cnt++;
        wr(3'd2, 16'h0001);
        rd(3'd4);
        tot_cnt++;
        if (bus_rd_data !== 16'h0009) $display("FAIL new_load got %h want 0009", bus_rd_data);
        else pass_cnt++;
        wr(3'd2, 16'h0000);
    endtask

    task automatic test_miss_and_wrap();
        int n;
        cyc(1'b1, 1'b0, BASE + 16'h0008, 16'h0000);
        tot_cnt++;
        if (bus_rd_data !== 16'h0000) $display("FAIL miss_read got %h want 0000", bus_rd_data);
        else pass_cnt++;
        cyc(1'b1, 1'b1, BASE + 16'h0009, 16'hFFFF);
        rd(3'd1);
        tot_cnt++;
        if (bus_rd_data !== 16'hA5A5) $display("FAIL miss_write got %h want a5a5", bus_rd_data);
        else pass_cnt++;
        rd(3'd6);
        tot_cnt++;
        if (bus_rd_data !== 16'(wr_exp)) $display("FAIL wrcnt_model got %h want %h", bus_rd_data, 16'(wr_exp));
        else pass_cnt++;
        n = 65536 - wr_exp;
        for (int i = 0; i < n; i++) wr(3'd7, 16'(i));
        rd(3'd6);
        tot_cnt++;
        if (bus_rd_data !== 16'h0000) $display("FAIL wrcnt_wrap got %h want 0000", bus_rd_data);
        else pass_cnt++;
        rd(3'd7);
        tot_cnt++;
        if (bus_rd_data !== 16'h0000) $display("FAIL rsvd_read got %h want 0000", bus_rd_data);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        wr(3'd3, 16'h0006);
        wr(3'd2, 16'h0005);
        rd(3'd1);
        tot_cnt++;
        if (bus_rd_data !== 16'hA5A5) $display("FAIL pre_rst_read got %h want a5a5", bus_rd_data);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        tot_cnt++;
        if (bus_rd_data !== 16'h0000) $display("FAIL async_rd_data got %h want 0000", bus_rd_data);
        else pass_cnt++;
        #2 rst = 1'b0;
        wr_exp = 0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            tot_cnt++;
            if (bus_rd_data !== exp_rst[i]) $display("FAIL post_rst ofs %0d got %h want %h", i, bus_rd_data, exp_rst[i]);
            else pass_cnt++;
        end
        rd(3'd4);
        tot_cnt++;
        if (bus_rd_data !== 16'h0000) $display("FAIL idle_after_rst got %h want 0000", bus_rd_data);
        else pass_cnt++;
        tot_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_after_rst got %b want 0", irq);
        else pass_cnt++;
    endtask

    initial begin
        exp_rst = '{16'hB5A1, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        test_reset();
        test_scratch();
        test_timer_oneshot();
        test_autoreload();
        test_run_boundary();
        test_miss_and_wrap();
        test_async_reset();
        idle();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
